// File: rtl/backbone_product_acc.sv
// Backbone product accumulator: selects one message per variable node, optionally skips one node,
// and reduces the selections by saturating fixed-point product (mode 0) or saturating sum (mode 1).
module backbone_product_acc #(
  parameter int J    = 14,
  parameter int A    = 2,
  parameter int DW   = 32,
  parameter int FRAC = 16,
  localparam int J_WIDTH = $clog2(J) + 1,
  localparam int A_WIDTH = $clog2(A) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [J*A*DW-1:0]      s_alpha_u,
  input  logic [J*A_WIDTH-1:0]   s_x_initial,
  input  logic [J_WIDTH-1:0]     s_ind_j,
  input  logic                   s_excl_en,
  input  logic                   s_mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DW-1:0]          m_result,
  output logic                   m_sat,
  output logic                   m_idx_err,
  output logic                   m_valid,
  input  logic                   m_ready
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic signed [2*DW-1:0] HALF = (2*DW)'(1) << (FRAC - 1);
  localparam logic signed [2*DW-1:0] MAXW = ((2*DW)'(1) << (DW - 1)) - (2*DW)'(1);
  localparam logic signed [2*DW-1:0] MINW = -((2*DW)'(1) << (DW - 1));
  localparam logic signed [DW-1:0]   ONE  = DW'(1) << FRAC;

  state_t                  state;
  logic [J_WIDTH-1:0]      cnt;
  logic signed [DW-1:0]    acc;
  logic                    sat_q;
  logic                    err_q;
  logic                    mode_q;
  logic                    excl_q;
  logic [J_WIDTH-1:0]      ind_q;
  logic [DW-1:0]           alpha_q [J][A];
  logic [A_WIDTH-1:0]      x_q [J];

  logic [A_WIDTH-1:0]      x_cur;
  logic signed [DW-1:0]    sel;
  logic                    skip_excl;
  logic                    bad_idx;
  logic signed [2*DW-1:0]  prod;
  logic signed [DW:0]      sum;
  logic signed [2*DW-1:0]  wide;
  logic signed [DW-1:0]    acc_next;
  logic                    sat_hit;

  assign s_ready = (state == IDLE) && !rst;

  // Datapath for the node under cnt; exclusion takes precedence over a bad selector.
  always_comb begin
    x_cur = '0;
    sel   = '0;
    for (int j = 0; j < J; j++) begin
      if (cnt == J_WIDTH'(j)) begin
        x_cur = x_q[j];
        for (int a = 0; a < A; a++) begin
          if (x_q[j] == A_WIDTH'(a)) sel = alpha_q[j][a];
        end
      end
    end
    skip_excl = excl_q && (cnt == ind_q);
    bad_idx   = x_cur >= A_WIDTH'(A);
    prod = $signed({{DW{acc[DW-1]}}, acc}) * $signed({{DW{sel[DW-1]}}, sel});
    sum  = $signed({acc[DW-1], acc}) + $signed({sel[DW-1], sel});
    if (mode_q) wide = {{(DW-1){sum[DW]}}, sum};
    else        wide = (prod + HALF) >>> FRAC;
    sat_hit  = 1'b0;
    acc_next = wide[DW-1:0];
    if (wide > MAXW) begin
      acc_next = MAXW[DW-1:0];
      sat_hit  = 1'b1;
    end else if (wide < MINW) begin
      acc_next = MINW[DW-1:0];
      sat_hit  = 1'b1;
    end
    if (skip_excl || bad_idx) begin
      acc_next = acc;
      sat_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      m_valid   <= 1'b0;
      m_result  <= '0;
      m_sat     <= 1'b0;
      m_idx_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            for (int j = 0; j < J; j++) begin
              x_q[j] <= s_x_initial[j*A_WIDTH +: A_WIDTH];
              for (int a = 0; a < A; a++) begin
                alpha_q[j][a] <= s_alpha_u[(j*A+a)*DW +: DW];
              end
            end
            ind_q  <= s_ind_j;
            excl_q <= s_excl_en;
            mode_q <= s_mode;
            cnt    <= '0;
            sat_q  <= 1'b0;
            err_q  <= 1'b0;
            acc    <= s_mode ? '0 : ONE;
            state  <= ACC;
          end
        end
        ACC: begin
          acc   <= acc_next;
          sat_q <= sat_q | sat_hit;
          err_q <= err_q | (bad_idx && !skip_excl);
          cnt   <= cnt + J_WIDTH'(1);
          if (cnt == J_WIDTH'(J - 1)) state <= OUT;
        end
        OUT: begin
          if (!m_valid) begin
            m_valid   <= 1'b1;
            m_result  <= acc;
            m_sat     <= sat_q;
            m_idx_err <= err_q;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backbone_product_acc.sv
// Self-checking bench for backbone_product_acc: directed plan cases plus randomized
// transactions scored against a plain-arithmetic reference model.
module tb_backbone_product_acc;
  localparam int J = 4, A = 2, DW = 32, FRAC = 16, JW = 3, AW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [J*A*DW-1:0] s_alpha_u;
  logic [J*AW-1:0]   s_x_initial;
  logic [JW-1:0]     s_ind_j;
  logic              s_excl_en, s_mode, s_valid, s_ready;
  logic [DW-1:0]     m_result;
  logic              m_sat, m_idx_err, m_valid, m_ready;

  int checks = 0;
  int failures = 0;

  logic [31:0]   alpha [J][A];
  logic [AW-1:0] xi [J];

  backbone_product_acc #(.J(J), .A(A), .DW(DW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .s_alpha_u(s_alpha_u), .s_x_initial(s_x_initial),
    .s_ind_j(s_ind_j), .s_excl_en(s_excl_en), .s_mode(s_mode), .s_valid(s_valid),
    .s_ready(s_ready), .m_result(m_result), .m_sat(m_sat), .m_idx_err(m_idx_err),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: walk the nodes in order with 64-bit arithmetic and clamp after each step.
  function automatic void model(input bit mode, input bit excl, input int ind,
                                output logic [31:0] r, output logic s, output logic e);
    longint acc, v, sv;
    int x;
    acc = mode ? 64'sd0 : 64'sd65536;
    s = 1'b0;
    e = 1'b0;
    for (int j = 0; j < J; j++) begin
      x = int'(xi[j]);
      if (excl && j == ind) continue;
      if (x >= A) begin
        e = 1'b1;
        continue;
      end
      sv = longint'($signed(alpha[j][x]));
      if (mode) v = acc + sv;
      else      v = (acc * sv + 64'sd32768) >>> 16;
      if (v > 64'sd2147483647) begin
        v = 64'sd2147483647;
        s = 1'b1;
      end else if (v < -64'sd2147483648) begin
        v = -64'sd2147483648;
        s = 1'b1;
      end
      acc = v;
    end
    r = acc[31:0];
  endfunction

  task automatic setSel(input logic [31:0] v0, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] v3);
    for (int j = 0; j < J; j++) begin
      alpha[j][0] = $urandom;
      xi[j] = 2'd1;
    end
    alpha[0][1] = v0;
    alpha[1][1] = v1;
    alpha[2][1] = v2;
    alpha[3][1] = v3;
  endtask

  task automatic applyStimulus(input bit mode, input bit excl, input logic [JW-1:0] ind);
    for (int j = 0; j < J; j++) begin
      s_x_initial[j*AW +: AW] = xi[j];
      for (int a = 0; a < A; a++) s_alpha_u[(j*A+a)*DW +: DW] = alpha[j][a];
    end
    s_mode = mode;
    s_excl_en = excl;
    s_ind_j = ind;
  endtask

  task automatic scramble();
    for (int k = 0; k < J*A; k++) s_alpha_u[k*DW +: DW] = $urandom;
    s_x_initial = J*AW'($urandom);
    s_mode = ~s_mode;
    s_excl_en = ~s_excl_en;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (m_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] r, input logic s, input logic e);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_result"}, m_result, r);
    check({tag, "_sat"}, 32'(m_sat), 32'(s));
    check({tag, "_idxerr"}, 32'(m_idx_err), 32'(e));
  endtask

  task automatic runTxn(input string tag, input bit mode, input bit excl, input logic [JW-1:0] ind,
                        input logic [31:0] r, input logic s, input logic e);
    int lat;
    @(negedge clk);
    applyStimulus(mode, excl, ind);
    s_valid = 1'b1;
    #1;
    check({tag, "_sready"}, 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    scramble();
    waitValid(lat);
    check({tag, "_latency"}, 32'(lat), 32'(J + 1));
    checkOutput(tag, r, s, e);
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic es, ee;
    int lat;
    bit seen;
    bit md, ex;
    logic [JW-1:0] id;

    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    s_alpha_u = '0;
    s_x_initial = '0;
    s_ind_j = '0;
    s_excl_en = 1'b0;
    s_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sready", 32'(s_ready), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_result", m_result, 32'd0);
    check("rst_sat", 32'(m_sat), 32'd0);
    check("rst_idxerr", 32'(m_idx_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_sready", 32'(s_ready), 32'd1);

    setSel(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
    runTxn("prod", 1'b0, 1'b0, 3'd0, 32'h00100000, 1'b0, 1'b0);
    runTxn("excl2", 1'b0, 1'b1, 3'd2, 32'h00080000, 1'b0, 1'b0);
    runTxn("excl7", 1'b0, 1'b1, 3'd7, 32'h00100000, 1'b0, 1'b0);

    setSel(32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000);
    runTxn("satpos", 1'b0, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
    setSel(32'hFF000000, 32'h01000000, 32'h00010000, 32'h00010000);
    runTxn("satneg", 1'b0, 1'b0, 3'd0, 32'h80000000, 1'b1, 1'b0);

    setSel(32'h00018000, 32'hFFFFC000, 32'h00008000, 32'h0000C000);
    runTxn("logsum", 1'b1, 1'b0, 3'd0, 32'h00028000, 1'b0, 1'b0);
    xi[3] = 2'd3;
    runTxn("idxerr", 1'b1, 1'b0, 3'd0, 32'h0001C000, 1'b0, 1'b1);

    // Backpressure: first transaction stalls in OUT while a second waits with s_valid high.
    m_ready = 1'b0;
    setSel(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    setSel(32'h00018000, 32'hFFFFC000, 32'h00008000, 32'h0000C000);
    applyStimulus(1'b1, 1'b0, 3'd0);
    waitValid(lat);
    check("bp_latency", 32'(lat), 32'(J + 1));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_result", m_result, 32'h00100000);
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_sready", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(m_valid), 32'd0);
    check("bp_release_sready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("bp_second_accept", 32'(s_ready), 32'd0);
    scramble();
    waitValid(lat);
    check("bp_second_latency", 32'(lat), 32'(J + 1));
    checkOutput("bp_second", 32'h00028000, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of accumulation abandons the transaction.
    setSel(32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 3'd0);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sready_low", 32'(s_ready), 32'd0);
    check("midrst_mvalid", 32'(m_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_sready", 32'(s_ready), 32'd1);
    seen = 1'b0;
    repeat (J + 3) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    setSel(32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000);
    runTxn("postrst", 1'b0, 1'b0, 3'd0, 32'h00100000, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      for (int j = 0; j < J; j++) begin
        for (int a = 0; a < A; a++) begin
          if ($urandom_range(0, 7) == 0) alpha[j][a] = $urandom;
          else alpha[j][a] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
        end
        xi[j] = ($urandom_range(0, 7) == 0) ? 2'd3 : AW'($urandom_range(0, 1));
      end
      md = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      id = JW'($urandom_range(0, 7));
      model(md, ex, int'(id), er, es, ee);
      runTxn($sformatf("rand%0d", t), md, ex, id, er, es, ee);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
